// File: rtl/pl_accessory_port_pkg.sv
// Shared types and constants for the G-15 PL19/PL20 accessory endpoint.
package g15_accessory_pkg;

    // Bits per character on both the PL19 input and PL20 output paths.
    localparam int DEFAULT_CHAR_BITS = 5;

    // Input-side sequencer states.
    typedef enum logic [1:0] {
        IN_IDLE  = 2'd0,
        IN_ARMED = 2'd1,
        IN_SHIFT = 2'd2
    } in_state_t;

endpackage

// File: rtl/pl_accessory_port_if.sv
// Parallel device-side interface of the accessory endpoint.
//
// Handshake rule for both channels: a character moves on a rising clock edge
// exactly when valid and ready are both high in the cycle before that edge.
// The source holds data stable while valid is high and ready is low; valid
// does not wait on ready, and ready may depend combinationally on valid.
interface pl_accessory_port_if
    import g15_accessory_pkg::*;
#(
    parameter int CHAR_BITS = DEFAULT_CHAR_BITS
);
    // Device -> CPU (PL19 input path)
    logic [CHAR_BITS-1:0] dev_in_data;
    logic                 dev_in_valid;
    logic                 dev_in_ready;

    // CPU -> device (PL20 output path)
    logic [CHAR_BITS-1:0] dev_out_data;
    logic                 dev_out_valid;
    logic                 dev_out_ready;

    // The attached device (tape, card reader, host bridge).
    modport master (
        output dev_in_data,
        output dev_in_valid,
        input  dev_in_ready,
        input  dev_out_data,
        input  dev_out_valid,
        output dev_out_ready
    );

    // The accessory port block itself.
    modport slave (
        input  dev_in_data,
        input  dev_in_valid,
        output dev_in_ready,
        output dev_out_data,
        output dev_out_valid,
        input  dev_out_ready
    );

endinterface

// File: rtl/pl_accessory_port_strobe.sv
// Rising-edge detector for one CPU strobe. The previous-value register
// resets to 1 so a strobe already high at reset release is not mistaken for
// a fresh edge; it must drop and rise again before it fires.
module pl_strobe_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);

    logic prev;

    // Track the strobe level from the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= sig;
        end
    end

    assign pulse = sig & ~prev;

endmodule

// File: rtl/pl_accessory_port.sv
// Accessory-side endpoint of the G-15 PL19/PL20 connectors. The input side
// serialises device characters onto PL19_INPUT under CPU shift strobes; the
// output side assembles PL20_OUTPUT bits into characters for the device.
// The two directions are independent.
module pl_accessory_port
    import g15_accessory_pkg::*;
#(
    parameter int CHAR_BITS = DEFAULT_CHAR_BITS,
    parameter int CNT_W     = $clog2(CHAR_BITS + 1)
) (
    input  logic               CLOCK,
    input  logic               rst,

    // PL19: CPU input path
    input  logic               PL19_START_INPUT,
    input  logic               PL19_STOP_INPUT,
    input  logic               PL19_SHIFT_CMD,
    input  logic               PL19_SHIFT_CMD_M20,
    input  logic               PL19_WRITE_PULSE,
    output logic               PL19_INPUT,
    output logic               PL19_READY_IN,

    // PL20: CPU output path
    input  logic               PL20_OUTPUT,
    input  logic               PL20_OUTPUT_SHIFT,
    output logic               PL20_READY_OUT,

    // Parallel device side
    pl_accessory_port_if.slave dev,

    // Sticky status
    input  logic               status_clear,
    output logic               in_abort,
    output logic               out_overrun,

    // Input sequencer state, for observation
    output in_state_t          in_state_dbg
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAR_BITS - 1);

    // The write pulse carries no meaning for this endpoint.
    logic unused_write_pulse;
    assign unused_write_pulse = PL19_WRITE_PULSE;

    // ------------------------------------------------------------------
    // Strobe conditioning
    // ------------------------------------------------------------------
    logic start_p;
    logic stop_p;
    logic shift_p;
    logic oshift_p;
    logic shift_raw;

    // Either shift source advances the input character.
    assign shift_raw = PL19_SHIFT_CMD | PL19_SHIFT_CMD_M20;

    pl_strobe_edge u_start_edge (
        .clk   (CLOCK),
        .rst   (rst),
        .sig   (PL19_START_INPUT),
        .pulse (start_p)
    );

    pl_strobe_edge u_stop_edge (
        .clk   (CLOCK),
        .rst   (rst),
        .sig   (PL19_STOP_INPUT),
        .pulse (stop_p)
    );

    pl_strobe_edge u_shift_edge (
        .clk   (CLOCK),
        .rst   (rst),
        .sig   (shift_raw),
        .pulse (shift_p)
    );

    pl_strobe_edge u_oshift_edge (
        .clk   (CLOCK),
        .rst   (rst),
        .sig   (PL20_OUTPUT_SHIFT),
        .pulse (oshift_p)
    );

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    in_state_t            in_state;
    in_state_t            in_state_nxt;
    logic [CHAR_BITS-1:0] shreg;
    logic [CNT_W-1:0]     cnt;
    logic                 in_ready;
    logic                 in_load;

    // Input sequencer state register.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            in_state <= IN_IDLE;
        end else begin
            in_state <= in_state_nxt;
        end
    end

    // Input sequencer next state and PL19/device outputs.
    always_comb begin
        in_state_nxt  = in_state;
        in_ready      = 1'b0;
        PL19_READY_IN = 1'b0;
        PL19_INPUT    = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (start_p) begin
                    in_state_nxt = IN_ARMED;
                end
            end
            IN_ARMED: begin
                // Refuse the character in a STOP cycle so a handshaken
                // character is never silently discarded.
                in_ready = ~stop_p;
                if (dev.dev_in_valid && !stop_p) begin
                    in_state_nxt = IN_SHIFT;
                end
            end
            IN_SHIFT: begin
                PL19_READY_IN = 1'b1;
                PL19_INPUT    = shreg[0];
                if (shift_p && (cnt == LAST_CNT)) begin
                    in_state_nxt = IN_ARMED;
                end
            end
            default: begin
                in_state_nxt = IN_IDLE;
            end
        endcase
        // STOP overrides everything, including a simultaneous START.
        if (stop_p) begin
            in_state_nxt = IN_IDLE;
        end
    end

    assign in_load          = dev.dev_in_valid & in_ready;
    assign dev.dev_in_ready = in_ready;
    assign in_state_dbg     = in_state;

    // Input character shifter and bit counter.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (stop_p) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (in_load) begin
            shreg <= dev.dev_in_data;
            cnt   <= '0;
        end else if ((in_state == IN_SHIFT) && shift_p) begin
            shreg <= shreg >> 1;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Sticky abort flag: STOP after at least one bit has left the shifter.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            in_abort <= 1'b0;
        end else if (stop_p && (in_state == IN_SHIFT) && (cnt != '0)) begin
            in_abort <= 1'b1;
        end else if (status_clear) begin
            in_abort <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output side
    // ------------------------------------------------------------------
    logic [CHAR_BITS-1:0] oshreg;
    logic [CHAR_BITS-1:0] oshreg_nxt;
    logic [CNT_W-1:0]     ocnt;
    logic [CHAR_BITS-1:0] hold;
    logic                 hold_valid;
    logic                 ochar_done;
    logic                 out_load;

    // New bits enter at the top so the first bit received ends up in bit 0.
    assign oshreg_nxt = {PL20_OUTPUT, oshreg[CHAR_BITS-1:1]};
    assign ochar_done = oshift_p && (ocnt == LAST_CNT);
    // The holding register may take a new character if it is empty or the
    // device is draining it in this same cycle.
    assign out_load   = ochar_done && (!hold_valid || dev.dev_out_ready);

    // Output bit assembler.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            oshreg <= '0;
            ocnt   <= '0;
        end else if (oshift_p) begin
            oshreg <= oshreg_nxt;
            ocnt   <= ochar_done ? '0 : (ocnt + CNT_W'(1));
        end
    end

    // One-entry holding register toward the device; a load beats a drain.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (out_load) begin
            hold       <= oshreg_nxt;
            hold_valid <= 1'b1;
        end else if (dev.dev_out_ready) begin
            hold_valid <= 1'b0;
        end
    end

    // Sticky overrun flag: a finished character found the holder occupied.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            out_overrun <= 1'b0;
        end else if (ochar_done && !out_load) begin
            out_overrun <= 1'b1;
        end else if (status_clear) begin
            out_overrun <= 1'b0;
        end
    end

    assign dev.dev_out_data  = hold;
    assign dev.dev_out_valid = hold_valid;
    assign PL20_READY_OUT    = ~hold_valid;

endmodule

// File: tb/tb_pl_accessory_port.sv
// Self-checking bench for pl_accessory_port: directed scenarios followed by
// random operations, compared against a queue-based reference model.
module tb_pl_accessory_port;
    import g15_accessory_pkg::*;

    localparam int W = 5;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic CLOCK = 1'b0;
    logic rst;
    always #5 CLOCK = ~CLOCK;

    logic PL19_START_INPUT, PL19_STOP_INPUT, PL19_SHIFT_CMD, PL19_SHIFT_CMD_M20;
    logic PL19_WRITE_PULSE, PL20_OUTPUT, PL20_OUTPUT_SHIFT;
    logic PL19_INPUT, PL19_READY_IN, PL20_READY_OUT;
    logic status_clear, in_abort, out_overrun;
    in_state_t in_state_dbg;

    pl_accessory_port_if #(.CHAR_BITS(W)) dif ();

    pl_accessory_port #(.CHAR_BITS(W)) dut (
        .CLOCK              (CLOCK),
        .rst                (rst),
        .PL19_START_INPUT   (PL19_START_INPUT),
        .PL19_STOP_INPUT    (PL19_STOP_INPUT),
        .PL19_SHIFT_CMD     (PL19_SHIFT_CMD),
        .PL19_SHIFT_CMD_M20 (PL19_SHIFT_CMD_M20),
        .PL19_WRITE_PULSE   (PL19_WRITE_PULSE),
        .PL19_INPUT         (PL19_INPUT),
        .PL19_READY_IN      (PL19_READY_IN),
        .PL20_OUTPUT        (PL20_OUTPUT),
        .PL20_OUTPUT_SHIFT  (PL20_OUTPUT_SHIFT),
        .PL20_READY_OUT     (PL20_READY_OUT),
        .dev                (dif),
        .status_clear       (status_clear),
        .in_abort           (in_abort),
        .out_overrun        (out_overrun),
        .in_state_dbg       (in_state_dbg)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: pending input bits, collected output bits, holder
    // ------------------------------------------------------------------
    bit           m_session;
    logic         m_in_q[$];
    logic         m_out_q[$];
    logic [W-1:0] m_hold;
    bit           m_hold_v;
    bit           m_abort;
    bit           m_ovr;

    function automatic void model_reset();
        m_session = 1'b0;
        m_in_q.delete();
        m_out_q.delete();
        m_hold   = '0;
        m_hold_v = 1'b0;
        m_abort  = 1'b0;
        m_ovr    = 1'b0;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_bit;
        exp_bit = (m_in_q.size() > 0) ? m_in_q[0] : 1'b0;
        chk({tag, ":pl19_input"},  PL19_INPUT, exp_bit);
        chk({tag, ":ready_in"},    PL19_READY_IN, m_in_q.size() > 0);
        chk({tag, ":dev_in_rdy"},  dif.dev_in_ready, m_session && (m_in_q.size() == 0));
        chk({tag, ":ready_out"},   PL20_READY_OUT, !m_hold_v);
        chk({tag, ":out_valid"},   dif.dev_out_valid, m_hold_v);
        chk({tag, ":out_data"},    dif.dev_out_data, m_hold);
        chk({tag, ":in_abort"},    in_abort, m_abort);
        chk({tag, ":out_overrun"}, out_overrun, m_ovr);
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (each strobe: one cycle high, one cycle low)
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_start();
        PL19_START_INPUT = 1'b1;
        cyc();
        PL19_START_INPUT = 1'b0;
        m_session = 1'b1;
        cyc();
    endtask

    task automatic do_stop();
        PL19_STOP_INPUT = 1'b1;
        cyc();
        PL19_STOP_INPUT = 1'b0;
        if (m_in_q.size() > 0 && m_in_q.size() < W) m_abort = 1'b1;
        m_session = 1'b0;
        m_in_q.delete();
        cyc();
    endtask

    task automatic do_start_stop();
        PL19_START_INPUT = 1'b1;
        PL19_STOP_INPUT  = 1'b1;
        cyc();
        PL19_START_INPUT = 1'b0;
        PL19_STOP_INPUT  = 1'b0;
        if (m_in_q.size() > 0 && m_in_q.size() < W) m_abort = 1'b1;
        m_session = 1'b0;
        m_in_q.delete();
        cyc();
    endtask

    task automatic do_in_shift(input bit use_m20);
        if (use_m20) PL19_SHIFT_CMD_M20 = 1'b1;
        else         PL19_SHIFT_CMD     = 1'b1;
        cyc();
        PL19_SHIFT_CMD     = 1'b0;
        PL19_SHIFT_CMD_M20 = 1'b0;
        if (m_in_q.size() > 0) void'(m_in_q.pop_front());
        cyc();
    endtask

    task automatic do_load(input logic [W-1:0] d);
        chk("load_in_ready", dif.dev_in_ready, 1'b1);
        dif.dev_in_data  = d;
        dif.dev_in_valid = 1'b1;
        cyc();
        dif.dev_in_valid = 1'b0;
        for (int i = 0; i < W; i++) m_in_q.push_back(d[i]);
    endtask

    task automatic do_out_shift(input logic b, input logic r, input logic clr);
        logic [W-1:0] c;
        PL20_OUTPUT       = b;
        dif.dev_out_ready = r;
        status_clear      = clr;
        PL20_OUTPUT_SHIFT = 1'b1;
        cyc();
        PL20_OUTPUT_SHIFT = 1'b0;
        dif.dev_out_ready = 1'b0;
        status_clear      = 1'b0;
        if (clr) begin
            m_abort = 1'b0;
            m_ovr   = 1'b0;
        end
        m_out_q.push_back(b);
        if (m_out_q.size() == W) begin
            for (int i = 0; i < W; i++) c[i] = m_out_q[i];
            m_out_q.delete();
            if (!m_hold_v || r) begin
                m_hold   = c;
                m_hold_v = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (r) begin
            m_hold_v = 1'b0;
        end
        cyc();
    endtask

    task automatic do_out_char(input logic [W-1:0] c);
        for (int i = 0; i < W; i++) do_out_shift(c[i], 1'b0, 1'b0);
    endtask

    task automatic do_drain();
        dif.dev_out_ready = 1'b1;
        cyc();
        dif.dev_out_ready = 1'b0;
        m_hold_v = 1'b0;
    endtask

    task automatic do_clear();
        status_clear = 1'b1;
        cyc();
        status_clear = 1'b0;
        m_abort = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Absolute time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0] pat;
        int           op;

        PL19_START_INPUT   = 1'b0;
        PL19_STOP_INPUT    = 1'b0;
        PL19_SHIFT_CMD     = 1'b0;
        PL19_SHIFT_CMD_M20 = 1'b0;
        PL19_WRITE_PULSE   = 1'b0;
        PL20_OUTPUT        = 1'b0;
        PL20_OUTPUT_SHIFT  = 1'b0;
        status_clear       = 1'b0;
        dif.dev_in_data    = '0;
        dif.dev_in_valid   = 1'b0;
        dif.dev_out_ready  = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        check_all("reset");
        chk("reset_state", in_state_dbg, IN_IDLE);

        // Input, normal character
        do_start();
        chk("start_state", in_state_dbg, IN_ARMED);
        check_all("armed");
        pat = 5'b10110;
        do_load(pat);
        for (int i = 0; i < W; i++) begin
            chk("in_bit_directed", PL19_INPUT, pat[i]);
            check_all("in_bits");
            do_in_shift(i[0]);
        end
        check_all("in_done");
        chk("in_done_state", in_state_dbg, IN_ARMED);

        // Input, abort after two bits
        do_load(5'b00001);
        do_in_shift(1'b0);
        do_in_shift(1'b1);
        do_stop();
        chk("abort_flag", in_abort, 1'b1);
        chk("abort_state", in_state_dbg, IN_IDLE);
        check_all("abort");
        do_clear();
        chk("abort_cleared", in_abort, 1'b0);
        check_all("abort_clr");

        // START and STOP in the same cycle
        do_start_stop();
        chk("start_stop_state", in_state_dbg, IN_IDLE);
        check_all("start_stop");

        // Output, normal character: bits 1,0,0,1,1
        do_out_char(5'b11001);
        chk("out_data_directed", dif.dev_out_data, 5'b11001);
        check_all("out_char");
        do_drain();
        check_all("out_drain");

        // Output overrun: two characters with no drain
        do_out_char(5'b11001);
        do_out_char(5'b01010);
        chk("ovr_flag", out_overrun, 1'b1);
        chk("ovr_keep_first", dif.dev_out_data, 5'b11001);
        check_all("overrun");
        // Overrun again with status_clear on the final edge: set wins
        do_clear();
        for (int i = 0; i < W - 1; i++) do_out_shift(1'b1, 1'b0, 1'b0);
        do_out_shift(1'b0, 1'b0, 1'b1);
        chk("ovr_set_wins", out_overrun, 1'b1);
        check_all("ovr_set_wins");
        do_drain();
        do_clear();
        check_all("ovr_clr");

        // Shift strobe held high through reset release
        rst = 1'b1;
        PL19_SHIFT_CMD = 1'b1;
        cyc();
        model_reset();
        rst = 1'b0;
        repeat (2) cyc();
        check_all("rst_hold_shift");
        do_start();
        do_load(5'b00101);
        repeat (3) cyc();
        chk("no_shift_while_held", PL19_INPUT, 1'b1);
        check_all("held_shift");
        PL19_SHIFT_CMD = 1'b0;
        cyc();
        PL19_SHIFT_CMD = 1'b1;
        cyc();
        void'(m_in_q.pop_front());
        chk("shift_after_rearm", PL19_INPUT, 1'b0);
        check_all("rearm_shift");
        PL19_SHIFT_CMD = 1'b0;
        cyc();

        // Reset in the middle of a character
        do_in_shift(1'b0);
        do_out_char(5'b10011);
        do_out_shift(1'b1, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        chk("rst_mid_state", in_state_dbg, IN_IDLE);
        @(negedge CLOCK);
        rst = 1'b0;
        cyc();
        check_all("rst_mid_rel");

        // Random operations against the model
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: do_start();
                1: begin
                    if ($urandom_range(0, 3) == 0) do_stop();
                    else do_in_shift($urandom_range(0, 1));
                end
                2, 3: do_in_shift($urandom_range(0, 1));
                4: begin
                    if (m_session && m_in_q.size() == 0) do_load(W'($urandom_range(0, (1 << W) - 1)));
                    else cyc();
                end
                5, 6, 7: do_out_shift($urandom_range(0, 1), $urandom_range(0, 3) == 0,
                                      $urandom_range(0, 7) == 0);
                8: do_drain();
                default: begin
                    if ($urandom_range(0, 1) == 0) do_clear();
                    else cyc();
                end
            endcase
            check_all("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pl_accessory_port.md
# pl_accessory_port

Accessory-side endpoint of the G-15 PL19/PL20 accessory connectors. It feeds serial characters into the CPU's PL19 input path and collects serial characters from the CPU's PL20 output path. It sits outside the CPU core, between the PL19/PL20 signals and a parallel device interface such as a tape, card or host bridge. Each direction is an independent state machine driven by edge-detected CPU strobes.

## Interface
- CHAR_BITS, 5, bits per character in both directions; shifted LSB first.
- CNT_W, $clog2(CHAR_BITS+1), width of the bit counters.

Ports:
- CLOCK  in  1  system clock; every register is clocked on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- PL19_START_INPUT  in  1  CPU requests input; acted on at its rising edge.
- PL19_STOP_INPUT  in  1  CPU ends input; acted on at its rising edge.
- PL19_SHIFT_CMD  in  1  shift one input bit; acted on at its rising edge.
- PL19_SHIFT_CMD_M20  in  1  shift one input bit when the M20 path is selected; ORed with PL19_SHIFT_CMD before edge detection.
- PL19_WRITE_PULSE  in  1  ignored by this block.
- PL20_OUTPUT  in  1  CPU serial output data bit.
- PL20_OUTPUT_SHIFT  in  1  sample PL20_OUTPUT; acted on at its rising edge.
- PL19_INPUT  out  1  serial input bit to the CPU.
- PL19_READY_IN  out  1  an input character is loaded and shifting.
- PL20_READY_OUT  out  1  the output side can accept a character.
- dev_in_data  in  CHAR_BITS  character from the device.
- dev_in_valid  in  1  dev_in_data is valid.
- dev_in_ready  out  1  the block accepts dev_in_data this cycle.
- dev_out_data  out  CHAR_BITS  character assembled from the CPU.
- dev_out_valid  out  1  dev_out_data is valid.
- dev_out_ready  in  1  the device consumes dev_out_data this cycle.
- status_clear  in  1  synchronous clear of the sticky flags.
- in_abort  out  1  sticky: STOP arrived while a character was partially shifted.
- out_overrun  out  1  sticky: an output character completed while the holding register was full.

## Operation
Strobe conditioning:
- Each strobe is a registered previous value plus `cur & ~prev`, giving a one-clock internal pulse.
- The previous-value registers reset to 1, so a strobe that is already high at reset release does not fire.

Input side FSM: IN_IDLE, IN_ARMED, IN_SHIFT.
- IN_IDLE: START edge -> IN_ARMED.
- IN_ARMED: dev_in_ready = 1. When dev_in_valid & dev_in_ready, load shreg <= dev_in_data and cnt <= 0, then -> IN_SHIFT.
- IN_SHIFT: PL19_READY_IN = 1 and PL19_INPUT = shreg[0], driven combinationally from the register.
  - On a shift edge: shreg shifts right with 0 fill, and cnt increments.
  - When cnt reaches CHAR_BITS-1 and a shift edge arrives -> IN_ARMED. PL19_READY_IN drops in that same edge cycle, so the register is low from the next cycle.
- STOP edge in any state -> IN_IDLE. If STOP arrives in IN_SHIFT with cnt > 0, set in_abort.
- If START and STOP edges occur in the same cycle, STOP wins.
- A shift edge outside IN_SHIFT is ignored.
- In every state other than IN_SHIFT, PL19_INPUT = 0.

Output side (a shifter plus a one-entry holding register):
- Each PL20_OUTPUT_SHIFT edge inserts PL20_OUTPUT at bit CHAR_BITS-1 of oshreg, shifting right, and increments ocnt.
- On the edge that brings ocnt to CHAR_BITS:
  - If the holding register is empty or being drained this cycle: hold <= the assembled character, dev_out_valid <= 1.
  - Otherwise: drop the character and set out_overrun.
  - In both cases ocnt <= 0.
- dev_out_valid clears on dev_out_ready unless a new character loads in the same cycle. Load has priority over the clear.
- PL20_READY_OUT = ~dev_out_valid (registered state).

Flags:
- status_clear clears in_abort and out_overrun.
- If a flag set event and status_clear occur in the same cycle, the set wins.

## Timing
- Reset values:
  - Both FSMs idle; all counters and shift registers 0.
  - PL19_INPUT = 0, PL19_READY_IN = 0, dev_in_ready = 0.
  - PL20_READY_OUT = 1, dev_out_valid = 0, dev_out_data = 0.
  - in_abort = 0, out_overrun = 0.
- Strobe to action latency is 1 clock: the edge is detected in the cycle the strobe is first high, and the resulting state is visible the following cycle.
- Input handshake: the first bit is on PL19_INPUT, with READY_IN = 1, one clock after the dev handshake.
- Output: dev_out_valid rises one clock after the final shift edge.
- Strobes must be low for at least one clock between pulses. Back-to-back pulses without a low cycle count as one.
- Asserting rst mid-character discards all partial state without setting flags.

## Structure
- Package g15_accessory_pkg holds:
  - the enum in_state_t {IN_IDLE, IN_ARMED, IN_SHIFT};
  - the default CHAR_BITS constant.
- Sub-module pl_strobe_edge, instantiated once per strobe: one input, one-clock pulse output, previous-value register reset to 1.

## Test plan
- Input, normal case:
  - Stimulus: START, dev_in_data = 5'b10110, then 5 shift edges.
  - Required: PL19_INPUT reads 0,1,1,0,1. READY_IN drops after the 5th edge. The FSM is back in IN_ARMED with dev_in_ready = 1.
- Input, abort:
  - Stimulus: load 5'b00001, shift 2 bits, then STOP.
  - Required: in_abort = 1, FSM in IN_IDLE, READY_IN = 0, PL19_INPUT = 0. status_clear then clears in_abort.
- Input, START and STOP together:
  - Stimulus: START and STOP rise in the same cycle.
  - Required: FSM stays in IN_IDLE.
- Output, normal case:
  - Stimulus: shift in bits 1,0,0,1,1.
  - Required: dev_out_data = 5'b11001, dev_out_valid = 1, PL20_READY_OUT = 0. dev_out_ready then restores READY_OUT = 1.
- Output, overrun:
  - Stimulus: hold dev_out_ready = 0 and shift in two characters.
  - Required: out_overrun = 1, and dev_out_data still holds the first character.
- Reset boundary:
  - Stimulus: hold PL19_SHIFT_CMD high through reset release.
  - Required: no shift occurs until the strobe goes low and then rises again.
- Reset mid-character:
  - Stimulus: assert rst partway through an input character.
  - Required: all outputs return to their reset values immediately.
